// File: rtl/jtag_tap.sv
// jtag_tap: IEEE 1149.1 TAP controller with BYPASS and USER data registers.
// Defining JTAG_TAP_IDCODE_EN adds the IDCODE register and makes IDCODE the reset instruction.
module jtag_tap #(
    parameter int          IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE_VALUE  = 32'h1000_0001,
    parameter int          USER_DR_WIDTH = 32
) (
    input  logic                     tck,
    input  logic                     trst_n,
    input  logic                     tms,
    input  logic                     tdi,
    output logic                     tdo,
    output logic                     tdo_oe,
    output logic [3:0]               tap_state,
    output logic [IR_WIDTH-1:0]      ir_out,
    input  logic [USER_DR_WIDTH-1:0] user_capture_data,
    output logic [USER_DR_WIDTH-1:0] user_update_data,
    output logic                     user_update_stb
);
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR,
        UPDDR, SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR
    } state_t;
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] OP_RST = IR_WIDTH'(1);
`else
    localparam logic [IR_WIDTH-1:0] OP_RST = '1;
`endif
    state_t                   r_state, w_next;
    logic [IR_WIDTH-1:0]      r_ir_sr, r_ir, w_ir_cap;
    logic                     r_byp, r_tdo, r_oe, r_stb;
    logic [USER_DR_WIDTH-1:0] r_usr, r_upd;
    logic                     w_tlr, w_cap_ir, w_sh_ir, w_upd_ir, w_cap_dr, w_sh_dr, w_upd_dr;
    logic                     w_sel_user, w_sel_id, w_sel_byp, w_id_lsb, w_dr_lsb;
    // IR capture pattern: ...0101, so bit 0 is always 1
    for (genvar i = 0; i < IR_WIDTH; i++) begin : g_cap
        assign w_ir_cap[i] = (i % 2) == 0;
    end
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) r_state <= TLR;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            TLR:     w_next = tms ? TLR   : RTI;
            RTI:     w_next = tms ? SELDR : RTI;
            SELDR:   w_next = tms ? SELIR : CAPDR;
            CAPDR:   w_next = tms ? EX1DR : SHDR;
            SHDR:    w_next = tms ? EX1DR : SHDR;
            EX1DR:   w_next = tms ? UPDDR : PAUDR;
            PAUDR:   w_next = tms ? EX2DR : PAUDR;
            EX2DR:   w_next = tms ? UPDDR : SHDR;
            UPDDR:   w_next = tms ? SELDR : RTI;
            SELIR:   w_next = tms ? TLR   : CAPIR;
            CAPIR:   w_next = tms ? EX1IR : SHIR;
            SHIR:    w_next = tms ? EX1IR : SHIR;
            EX1IR:   w_next = tms ? UPDIR : PAUIR;
            PAUIR:   w_next = tms ? EX2IR : PAUIR;
            EX2IR:   w_next = tms ? UPDIR : SHIR;
            UPDIR:   w_next = tms ? SELDR : RTI;
            default: w_next = TLR;
        endcase
    end
    always_comb begin
        w_tlr    = r_state == TLR;
        w_cap_ir = r_state == CAPIR;
        w_sh_ir  = r_state == SHIR;
        w_upd_ir = r_state == UPDIR;
        w_cap_dr = r_state == CAPDR;
        w_sh_dr  = r_state == SHDR;
        w_upd_dr = r_state == UPDDR;
    end
    assign w_sel_user = 32'(r_ir) == 32'd8;
    assign w_sel_byp  = !w_sel_user && !w_sel_id;
`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] r_id;
    assign w_sel_id = 32'(r_ir) == 32'd1;
    assign w_id_lsb = r_id[0];
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n)                  r_id <= '0;
        else if (w_cap_dr && w_sel_id) r_id <= IDCODE_VALUE;
        else if (w_sh_dr && w_sel_id)  r_id <= {tdi, r_id[31:1]};
    end
`else
    assign w_sel_id = 1'b0;
    assign w_id_lsb = w_sel_id & IDCODE_VALUE[0];
`endif
    assign w_dr_lsb = w_sel_user ? r_usr[0] : w_sel_id ? w_id_lsb : r_byp;
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir_sr <= '0;
            r_byp   <= 1'b0;
            r_usr   <= '0;
        end else begin
            if (w_cap_ir)                   r_ir_sr <= w_ir_cap;
            else if (w_sh_ir)               r_ir_sr <= IR_WIDTH'({tdi, r_ir_sr} >> 1);
            if (w_cap_dr && w_sel_byp)      r_byp <= 1'b0;
            else if (w_sh_dr && w_sel_byp)  r_byp <= tdi;
            if (w_cap_dr && w_sel_user)     r_usr <= user_capture_data;
            else if (w_sh_dr && w_sel_user) r_usr <= USER_DR_WIDTH'({tdi, r_usr} >> 1);
        end
    end
    // Falling-edge side: outputs settle half a cycle before the next sampling rise
    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir  <= OP_RST;
            r_tdo <= 1'b0;
            r_oe  <= 1'b0;
            r_upd <= '0;
            r_stb <= 1'b0;
        end else begin
            r_ir  <= w_tlr ? OP_RST : w_upd_ir ? r_ir_sr : r_ir;
            r_tdo <= w_sh_ir ? r_ir_sr[0] : w_sh_dr ? w_dr_lsb : 1'b0;
            r_oe  <= w_sh_ir || w_sh_dr;
            r_upd <= (w_upd_dr && w_sel_user) ? r_usr : r_upd;
            r_stb <= w_upd_dr && w_sel_user;
        end
    end
    assign tap_state        = r_state;
    assign ir_out           = r_ir;
    assign tdo              = r_tdo;
    assign tdo_oe           = r_oe;
    assign user_update_data = r_upd;
    assign user_update_stb  = r_stb;
endmodule
